// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Misaligned or beyond the last word; high addresses never alias.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables; no reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, held response.
// Optional DMEM_STATS_EN adds saturating load/store counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       load_count,
    output logic [15:0]       store_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        wcnt;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_acc;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign req_ready = (state == IDLE) && reset;
    assign err_acc   = addr_err(addr_q, DEPTH_WORDS);
    assign ram_en    = (state == ACCESS) && !err_acc;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .be    (be_q),
        .addr  (addr_q[2 +: AW]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // RAM data lands one edge after ACCESS, so the first RESP cycle captures it
    // and raises rsp_valid; later RESP cycles wait for the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            wcnt  <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_acc;
                        rsp_rdata <= (we_q || err_acc) ? '0 : ram_rdata;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (ram_en) begin
            if (we_q) begin
                if (store_count != '1) store_count <= store_count + 16'd1;
            end else begin
                if (load_count != '1) load_count <= load_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (WAIT_STATES=1 and 4) sharing request wires.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        rr1, rv1, re1, rr4, rv4, re4;
    logic [31:0] rd1, rd4;
    logic        o_rr, o_rv, o_re;
    logic [31:0] o_rd;

`ifdef DMEM_STATS_EN
    logic [15:0] lc1, sc1, lc4, sc4;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ld_cnt   = 0;
    int unsigned st_cnt   = 0;
    exp_t        sb[$];
    logic [31:0] model [2][DEPTH];

    always #5 clk = ~clk;

    assign o_rr = sel ? rr4 : rr1;
    assign o_rv = sel ? rv4 : rv1;
    assign o_rd = sel ? rd4 : rd1;
    assign o_re = sel ? re4 : re1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut (
        .clk       (clk),
        .reset     (rst1),
        .req_valid (req_valid && !sel),
        .req_ready (rr1),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rv1),
        .rsp_ready (rsp_ready && !sel),
        .rsp_rdata (rd1),
        .rsp_err   (re1)
`ifdef DMEM_STATS_EN
        ,
        .load_count  (lc1),
        .store_count (sc1)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_dut4 (
        .clk       (clk),
        .reset     (rst4),
        .req_valid (req_valid && sel),
        .req_ready (rr4),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rv4),
        .rsp_ready (rsp_ready && sel),
        .rsp_rdata (rd4),
        .rsp_err   (re4)
`ifdef DMEM_STATS_EN
        ,
        .load_count  (lc4),
        .store_count (sc4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input bit s, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int unsigned hold);
        exp_t        e;
        bit          err;
        int unsigned idx;
        int unsigned n;
        err = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
        idx = 32'(addr[9:2]);
        if (!err && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[s][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (!err && !s) begin
            if (we) st_cnt++;
            else ld_cnt++;
        end
        e.err   = err;
        e.rdata = (we || err) ? 32'h0 : model[s][idx];
        sb.push_back(e);

        @(negedge clk);
        sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        n = 0;
        while (!o_rr && n < 50) begin @(negedge clk); n++; end
        if (!o_rr) begin
            check("accept_timeout", 32'(o_rr), 32'd1);
            req_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(negedge clk);
        // keep a junk request pending; it must not be latched outside IDLE
        req_addr = 32'hFFFF_FFF0; req_wdata = ~wdata; req_we = ~we;
        n = 0;
        while (!o_rv && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        check("latency", 32'(n), s ? 32'd6 : 32'd3);
        e = sb.pop_front();
        check("rsp_rdata", o_rd, e.rdata);
        check("rsp_err", 32'(o_re), 32'(e.err));
        check("req_ready_busy", 32'(o_rr), 32'd0);
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check("hold_valid", 32'(o_rv), 32'd1);
            check("hold_rdata", o_rd, e.rdata);
            check("hold_err", 32'(o_re), 32'(e.err));
            check("hold_ready", 32'(o_rr), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_valid", 32'(o_rv), 32'd0);
        check("post_rdata", o_rd, 32'd0);
        check("post_ready", 32'(o_rr), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b0; rst4 = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rr1), 32'd0);
        check("rst_valid", 32'(rv1), 32'd0);
        check("rst_rdata", rd1, 32'd0);
        check("rst_err", 32'(re1), 32'd0);
        rst1 = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(rr1), 32'd1);

        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        issue(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
        check("merge_const", model[0][4], 32'hDE22_BE44);
        issue(0, 1'b1, 32'h0, 32'hA5A5_5A5A, 4'hF, 0);
        issue(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
        issue(0, 1'b1, DEPTH * 4, 32'h0BAD_0BAD, 4'hF, 0);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        issue(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 0);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        issue(0, 1'b1, (DEPTH - 1) * 4, 32'h600D_CAFE, 4'hF, 0);
        issue(0, 1'b0, (DEPTH - 1) * 4, 32'h0, 4'h0, 0);
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
`ifdef DMEM_STATS_EN
        check("load_count", {16'h0, lc1}, 32'(ld_cnt));
        check("store_count", {16'h0, sc1}, 32'(st_cnt));
`endif

        issue(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !rr4; i++) @(negedge clk);
        check("wait_accept", 32'(rr4), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("midrst_valid", 32'(rv4), 32'd0);
        check("midrst_ready", 32'(rr4), 32'd0);
        check("midrst_rdata", rd4, 32'd0);
        @(negedge clk);
        rst4 = 1'b1;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
